// File: rtl/return_address_stack.sv
// Return address stack: circular call/return predictor with one branch snapshot.
// Ports: clk, rst_n, stall, push/push_addr, pop, ckpt, recover -> top_addr, top_valid, branch_stack_recovery.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module return_address_stack #(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic                  pop,
  input  logic                  ckpt,
  input  logic                  recover,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic                  top_valid,
  output logic [ADDR_WIDTH-1:0] branch_stack_recovery
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_tos;
  logic [CW-1:0]         r_cnt;
  logic [PW-1:0]         r_s_tos;
  logic [CW-1:0]         r_s_cnt;
  logic [ADDR_WIDTH-1:0] r_s_top;

  logic          w_push;
  logic          w_pop;
  logic          w_ckpt;
  logic [PW-1:0] w_tos_inc;
  logic [PW-1:0] w_tos_dec;
  logic          w_empty;

  assign w_push    = push & ~stall;
  assign w_pop     = pop  & ~stall;
  assign w_ckpt    = ckpt & ~stall;
  assign w_tos_inc = r_tos + PW'(1);
  assign w_tos_dec = r_tos - PW'(1);
  assign w_empty   = (r_cnt == '0);

  assign top_valid             = ~w_empty;
  assign top_addr              = w_empty ? '0 : r_mem[r_tos];
  assign branch_stack_recovery = r_s_top;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_tos   <= '0;
      r_cnt   <= '0;
      r_s_tos <= '0;
      r_s_cnt <= '0;
      r_s_top <= '0;
    end else if (recover) begin
      // Restoring the saved top entry repairs a slot a wrong-path
      // push may have clobbered; deeper slots are trusted as-is.
      r_tos          <= r_s_tos;
      r_cnt          <= r_s_cnt;
      r_mem[r_s_tos] <= r_s_top;
    end else begin
      if (w_ckpt) begin
        r_s_tos <= r_tos;
        r_s_cnt <= r_cnt;
        r_s_top <= r_mem[r_tos];
      end
      if (w_push && w_pop) begin
        // Call immediately after return: replace top in place.
        r_mem[r_tos] <= push_addr;
        if (w_empty) r_cnt <= CW'(1);
      end else if (w_push) begin
        // When full, the slot after tos is the oldest entry.
        r_tos            <= w_tos_inc;
        r_mem[w_tos_inc] <= push_addr;
        if (r_cnt != FULL) r_cnt <= r_cnt + CW'(1);
      end else if (w_pop && !w_empty) begin
        r_tos <= w_tos_dec;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_return_address_stack.sv
// Randomized + directed bench for return_address_stack.
// Reference model kept as an integer-indexed ring with a saved snapshot.
module tb_return_address_stack;

  localparam int AW = 32;
  localparam int D  = 8;

  logic          clk = 0;
  logic          rst_n;
  logic          stall, push, pop, ckpt, recover;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic          top_valid;
  logic [AW-1:0] branch_stack_recovery;

  int n_chk  = 0;
  int n_fail = 0;

  int          m_tos, m_cnt, s_tos, s_cnt;
  logic [31:0] m_ent [D];
  logic [31:0] s_top;

  return_address_stack #(.ADDR_WIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .push(push), .push_addr(push_addr), .pop(pop),
    .ckpt(ckpt), .recover(recover),
    .top_addr(top_addr), .top_valid(top_valid),
    .branch_stack_recovery(branch_stack_recovery)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_tos = 0; m_cnt = 0; s_tos = 0; s_cnt = 0; s_top = '0;
    for (int i = 0; i < D; i++) m_ent[i] = '0;
  endfunction

  function automatic void m_step(input logic ps, input logic [31:0] a,
                                 input logic pp, ck, rc, st);
    if (rc) begin
      m_tos = s_tos;
      m_cnt = s_cnt;
      m_ent[s_tos] = s_top;
    end else if (!st) begin
      if (ck) begin
        s_tos = m_tos; s_cnt = m_cnt; s_top = m_ent[m_tos];
      end
      if (ps && pp) begin
        m_ent[m_tos] = a;
        if (m_cnt == 0) m_cnt = 1;
      end else if (ps) begin
        m_tos = (m_tos + 1) % D;
        m_ent[m_tos] = a;
        if (m_cnt < D) m_cnt++;
      end else if (pp && m_cnt > 0) begin
        m_tos = (m_tos + D - 1) % D;
        m_cnt--;
      end
    end
  endfunction

  task automatic cmp_model(input string tag);
    chk({tag, "_top"}, top_addr, (m_cnt > 0) ? m_ent[m_tos] : 32'h0);
    chk({tag, "_vld"}, top_valid, m_cnt > 0);
    chk({tag, "_bsr"}, branch_stack_recovery, s_top);
  endtask

  task automatic cyc(input logic ps, input logic [31:0] a, input logic pp,
                     input logic ck, input logic rc, input logic st,
                     input string tag);
    push = ps; push_addr = a; pop = pp;
    ckpt = ck; recover = rc; stall = st;
    @(posedge clk);
    m_step(ps, a, pp, ck, rc, st);
    #1;
    cmp_model(tag);
    push = 0; pop = 0; ckpt = 0; recover = 0; stall = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    m_reset();
    chk("rst_top", top_addr, 0);
    chk("rst_vld", top_valid, 0);
    chk("rst_bsr", branch_stack_recovery, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0; stall = 0; push = 0; pop = 0;
    ckpt = 0; recover = 0; push_addr = '0;
    m_reset();
    #12;
    do_reset();

    // Three pushes, three pops
    cyc(1, 32'h100, 0, 0, 0, 0, "p1");
    cyc(1, 32'h200, 0, 0, 0, 0, "p2");
    cyc(1, 32'h300, 0, 0, 0, 0, "p3");
    chk("d031_top", top_addr, 32'h300);
    chk("d031_vld", top_valid, 1);
    cyc(0, 0, 1, 0, 0, 0, "q1");
    chk("d031_pop1", top_addr, 32'h200);
    cyc(0, 0, 1, 0, 0, 0, "q2");
    chk("d031_pop2", top_addr, 32'h100);
    cyc(0, 0, 1, 0, 0, 0, "q3");
    chk("d031_empty_vld", top_valid, 0);
    chk("d031_empty_top", top_addr, 0);

    // Overflow wrap and underflow
    do_reset();
    for (int i = 1; i <= 9; i++)
      cyc(1, 32'(i * 16), 0, 0, 0, 0, "wrap_push");
    chk("d032_top", top_addr, 32'h90);
    for (int k = 0; k < 8; k++) begin
      chk("d032_seq", top_addr, 32'(32'h90 - 16 * k));
      cyc(0, 0, 1, 0, 0, 0, "wrap_pop");
    end
    chk("d032_drained", top_valid, 0);
    cyc(0, 0, 1, 0, 0, 0, "underflow");
    chk("d032_uf_vld", top_valid, 0);
    chk("d032_uf_top", top_addr, 0);

    // Same-cycle push and pop
    do_reset();
    cyc(1, 32'h100, 0, 0, 0, 0, "s1");
    cyc(1, 32'h200, 0, 0, 0, 0, "s2");
    cyc(1, 32'h400, 1, 0, 0, 0, "spp");
    chk("d033_top", top_addr, 32'h400);
    cyc(0, 0, 1, 0, 0, 0, "spop");
    chk("d033_next", top_addr, 32'h100);

    // Checkpoint with pop, then recover overrides push
    do_reset();
    cyc(1, 32'h100, 0, 0, 0, 0, "c1");
    cyc(1, 32'h200, 0, 0, 0, 0, "c2");
    cyc(0, 0, 1, 1, 0, 0, "ckpop");
    chk("d034_bsr", branch_stack_recovery, 32'h200);
    chk("d034_top", top_addr, 32'h100);
    cyc(1, 32'h500, 0, 0, 1, 0, "rec");
    chk("d034_rec_top", top_addr, 32'h200);
    cyc(0, 0, 1, 0, 0, 0, "rec_pop");
    chk("d034_cnt2", top_addr, 32'h100);

    // Stall gating, recover not gated
    do_reset();
    cyc(1, 32'h100, 0, 0, 0, 0, "t1");
    cyc(1, 32'h200, 0, 0, 0, 0, "t2");
    cyc(0, 0, 0, 1, 0, 0, "tck");
    cyc(1, 32'h700, 1, 1, 0, 1, "tstall");
    chk("d035_top", top_addr, 32'h200);
    chk("d035_bsr", branch_stack_recovery, 32'h200);
    cyc(0, 0, 1, 0, 0, 0, "tpop");
    chk("d035_pop", top_addr, 32'h100);
    cyc(0, 0, 0, 0, 1, 1, "trec");
    chk("d035_rec", top_addr, 32'h200);

    // Asynchronous reset mid-operation
    cyc(1, 32'h300, 0, 1, 0, 0, "a3");
    #2;
    rst_n = 0;
    #1;
    m_reset();
    chk("d036_top", top_addr, 0);
    chk("d036_vld", top_valid, 0);
    chk("d036_bsr", branch_stack_recovery, 0);
    #1;
    rst_n = 1;
    cyc(1, 32'h800, 0, 0, 0, 0, "a_push");
    chk("d036_push", top_addr, 32'h800);
    cyc(0, 0, 1, 0, 0, 0, "a_pop");
    chk("d036_cnt1", top_valid, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 2) == 0, $urandom,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 11) == 0,
            $urandom_range(0, 5) == 0, "rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
